uart_line_arbiter: RTL and testbench



---
 rtl/uart_line_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_line_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_arbiter.sv
// Line-atomic round-robin arbiter sharing one console UART between NUM_REQ character streams.
// Latency: terminator pushed in cycle t -> grant at t+1 -> first char at t+2; one char/cycle after.
// Backpressure: in_ready drops only on a full FIFO; out_valid/out_ch hold until out_ready. Tag option: UART_ARB_TAG_EN.
module uart_line_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [8*NUM_REQ-1:0] in_ch,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic                 out_valid,
    output logic [7:0]           out_ch,
    input  logic                 out_ready,
    output logic                 trap_valid,
    output logic [ID_W-1:0]      trap_id,
    output logic                 busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE, TAG0, TAG1, SEND} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h0A) || c[7];
    endfunction

    logic [7:0]      mem      [NUM_REQ][FIFO_DEPTH];
    logic [AW:0]     wr_ptr   [NUM_REQ];
    logic [AW:0]     rd_ptr   [NUM_REQ];
    logic [CW-1:0]   term_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] full, empty, eligible, push, pop, push_term, pop_term;

    state_t          state;
    logic [ID_W-1:0] grant, rr, next_grant;
    logic [ID_W:0]   cand;
    logic            any_elig, halted, pop_any, line_end;
    logic [AW:0]     sent_cnt;
    logic [7:0]      head;
    logic            head_term;

    assign head      = mem[grant][rd_ptr[grant][AW-1:0]];
    assign head_term = is_term(head);
    assign pop_any   = (state == SEND) && out_valid && out_ready;
    assign line_end  = pop_any && (head_term || sent_cnt == (AW+1)'(FIFO_DEPTH - 1));
    assign busy      = (state != IDLE) || !(&empty);

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign full[k]      = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                              (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
        assign empty[k]     = (wr_ptr[k] == rd_ptr[k]);
        assign in_ready[k]  = reset_n && !full[k];
        assign push[k]      = in_valid[k] && in_ready[k];
        assign pop[k]       = pop_any && (grant == ID_W'(k));
        assign push_term[k] = push[k] && is_term(in_ch[8*k +: 8]);
        assign pop_term[k]  = pop[k] && head_term;
        // A full FIFO with no terminator is flushed as a partial line.
        assign eligible[k]  = (term_cnt[k] != '0) || full[k];
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (push[k]) mem[k][wr_ptr[k][AW-1:0]] <= in_ch[8*k +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
                term_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
                if (push_term[k] && !pop_term[k])
                    term_cnt[k] <= term_cnt[k] + CW'(1);
                else if (!push_term[k] && pop_term[k])
                    term_cnt[k] <= term_cnt[k] - CW'(1);
            end
        end
    end

    // Scan descending so the candidate closest after rr wins.
    always_comb begin
        any_elig   = 1'b0;
        next_grant = rr;
        cand       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, rr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (eligible[cand[ID_W-1:0]]) begin
                any_elig   = 1'b1;
                next_grant = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_ch    = 8'h00;
        case (state)
`ifdef UART_ARB_TAG_EN
            TAG0: begin
                out_valid = 1'b1;
                out_ch    = 8'h30 + 8'(grant);
            end
            TAG1: begin
                out_valid = 1'b1;
                out_ch    = 8'h3A;
            end
`endif
            SEND: begin
                out_valid = !empty[grant];
                out_ch    = out_valid ? head : 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr         <= ID_W'(NUM_REQ - 1);
            sent_cnt   <= '0;
            halted     <= 1'b0;
            trap_valid <= 1'b0;
            trap_id    <= '0;
        end else begin
            trap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!halted && any_elig) begin
                        grant    <= next_grant;
                        rr       <= next_grant;
                        sent_cnt <= '0;
`ifdef UART_ARB_TAG_EN
                        state    <= TAG0;
`else
                        state    <= SEND;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG0: if (out_ready) state <= TAG1;
                TAG1: if (out_ready) state <= SEND;
`endif
                SEND: begin
                    if (pop_any) begin
                        sent_cnt <= sent_cnt + (AW+1)'(1);
                        if (head[7]) begin
                            trap_valid <= 1'b1;
                            trap_id    <= grant;
                            halted     <= 1'b1;
                        end
                        if (line_end) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Scoreboard bench for uart_line_arbiter: directed lines per requester, monitor pops expected console bytes.
module tb_uart_line_arbiter;
    localparam int NR  = 4;
    localparam int DEP = 16;
`ifdef UART_ARB_TAG_EN
    localparam int TAGN = 2;
`else
    localparam int TAGN = 0;
`endif

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [NR-1:0]   in_valid;
    logic [8*NR-1:0] in_ch;
    logic [NR-1:0]   in_ready;
    logic            out_valid;
    logic [7:0]      out_ch;
    logic            out_ready;
    logic            trap_valid;
    logic [1:0]      trap_id;
    logic            busy;

    uart_line_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(DEP)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ch(in_ch), .in_ready(in_ready),
        .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready),
        .trap_valid(trap_valid), .trap_id(trap_id), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    int trap_q[$];

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic exp_tag(int id);
        if (TAGN != 0) begin
            exp_q.push_back(8'h30 + 8'(id));
            exp_q.push_back(8'h3A);
        end
    endtask

    task automatic exp_line(int id, string s);
        exp_tag(id);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic push_ch(int k, logic [7:0] c);
        int t;
        t = 0;
        in_valid[k] = 1'b1;
        in_ch[8*k +: 8] = c;
        @(negedge clock);
        while (!in_ready[k] && t < 200) begin
            t++;
            @(negedge clock);
        end
        if (!in_ready[k]) chk("push_timeout", 0, 1);
        @(posedge clock);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic push_str(int k, string s);
        foreach (s[i]) push_ch(k, s[i]);
    endtask

    task automatic wait_valid(string name);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            t++;
            @(negedge clock);
        end
        if (!out_valid) chk(name, 0, 1);
    endtask

    task automatic drain(string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            @(negedge clock);
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    // Monitor: scoreboard pop, hold-while-stalled, and trap pulse timing.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_ch = 8'h00;
    logic       pend_trap = 1'b0;
    int         pend_id = 0;
    logic [7:0] e;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            pend_trap  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_ch", out_ch, prev_ch);
            end
            if (pend_trap || trap_valid) begin
                chk("trap_valid", trap_valid, pend_trap);
                if (pend_trap) chk("trap_id", trap_id, pend_id);
            end
            pend_trap = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ch", out_ch, e);
                    if (e[7]) begin
                        pend_trap = 1'b1;
                        pend_id = (trap_q.size() != 0) ? trap_q.pop_front() : -1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_ch    = out_ch;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int t0;
    int t;
    initial begin
        in_valid  = '0;
        in_ch     = '0;
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_trap_valid", trap_valid, 0);
        chk("rst_trap_id", trap_id, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 4'hF);

        // Single line, latency and busy fall.
        out_ready = 1'b1;
        @(posedge clock);
        #1 t0 = cyc;
        exp_line(0, "hi\n");
        push_str(0, "hi\n");
        wait_valid("t1_valid_timeout");
        chk("t1_first_latency", cyc - t0, 4);
        t = 0;
        while (busy && t < 50) begin
            t++;
            @(negedge clock);
        end
        chk("t1_busy_fall", cyc - t0, 7 + TAGN);
        drain("t1_drain");

        // Two buffered lines never interleave; then round-robin after rr=1 picks 2 over 0.
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_line(0, "ab\n");
        exp_line(1, "cd\n");
        push_str(0, "ab\n");
        push_str(1, "cd\n");
        out_ready = 1'b1;
        drain("t2_drain_a");
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_line(2, "f\n");
        exp_line(0, "e\n");
        fork
            push_str(0, "e\n");
            push_str(2, "f\n");
        join
        out_ready = 1'b1;
        drain("t2_drain_b");

        // Full FIFO flushed as a 16-char partial line, remainder held.
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_line(2, "ABCDEFGHIJKLMNOP");
        for (int i = 0; i < 16; i++) push_ch(2, 8'h41 + 8'(i));
        @(negedge clock);
        chk("t3_full_in_ready", in_ready[2], 0);
        @(posedge clock);
        #1 out_ready = 1'b1;
        for (int i = 16; i < 20; i++) push_ch(2, 8'h41 + 8'(i));
        drain("t3_drain");
        repeat (10) @(negedge clock);
        chk("t3_remainder_busy", busy, 1);
        chk("t3_remainder_idle", out_valid, 0);

        // Mid-line stall of five cycles; remainder line completes.
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_line(2, "QRSTUV\n");
        push_str(2, "UV\n");
        wait_valid("t5_valid_timeout");
        @(posedge clock);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
        drain("t5_drain");

        // Trap from requester 3 halts further grants.
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_line(3, "x\n");
        exp_line(1, "p\n");
        exp_tag(3);
        exp_q.push_back(8'h80);
        trap_q.push_back(3);
        push_str(3, "x\n");
        push_ch(3, 8'h80);
        push_str(1, "p\n");
        out_ready = 1'b1;
        drain("t4_drain");
        push_str(1, "q\n");
        repeat (40) @(negedge clock);
        chk("t4_halted_no_out", out_valid, 0);
        chk("t4_halted_busy", busy, 1);
        chk("t4_trap_q_used", trap_q.size(), 0);

        // Reset clears halt and buffered data.
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6a_trap_id", trap_id, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_in_ready", in_ready, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset mid-line discards the partially sent line.
        out_ready = 1'b0;
        push_str(0, "abcdef\n");
        wait_valid("t6_valid_timeout");
        exp_tag(0);
        exp_q.push_back("a");
        exp_q.push_back("b");
        @(posedge clock);
        #1 out_ready = 1'b1;
        repeat (TAGN + 2) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        chk("t6_stalled_valid", out_valid, 1);
        chk("t6_partial_sent", exp_q.size(), 0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_out_ch", out_ch, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_trap_valid", trap_valid, 0);
        chk("t6_async_in_ready", in_ready, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        exp_line(0, "z\n");
        push_str(0, "z\n");
        drain("t6_drain");
        repeat (20) @(negedge clock);
        chk("final_idle", busy, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
